rtc_bus_if: RTL and testbench

//  Multiplexed address/data bus master for the external RTC chip. It sits directly downstream of the

---
 rtl/rtc_bus_pkg.sv | 42 ++++
 rtl/rtc_phase_timer.sv | 27 ++
 rtl/rtc_bus_if.sv | 187 ++++++++++++++++++
 tb/tb_rtc_bus_if.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed bus master: state encoding,
// default phase timings, pin bundle type and RTC command codes.
package rtc_bus_pkg;

    localparam int T_SETUP_DEF = 2;
    localparam int T_PULSE_DEF = 4;
    localparam int T_HOLD_DEF  = 2;
    localparam int T_GAP_DEF   = 2;
    localparam int CNT_W_DEF   = 4;

    // Transfer commands written to the RTC control register
    localparam logic [7:0] CMD_XFER_TO_RTC   = 8'hF0;
    localparam logic [7:0] CMD_XFER_FROM_RTC = 8'hF1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_A_SETUP  = 4'd1,
        ST_A_STROBE = 4'd2,
        ST_A_HOLD   = 4'd3,
        ST_GAP      = 4'd4,
        ST_D_SETUP  = 4'd5,
        ST_D_STROBE = 4'd6,
        ST_D_HOLD   = 4'd7,
        ST_DONE     = 4'd8
    } rtc_state_e;

    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } rtc_op_e;

    typedef struct packed {
        logic cs_n;
        logic ad_n;
        logic wr_n;
        logic rd_n;
        logic ad_oe;
    } rtc_pins_t;

    localparam rtc_pins_t PINS_IDLE = '{cs_n: 1'b1, ad_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1, ad_oe: 1'b0};

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down counter timing each bus phase; last flags the final cycle.
module rtc_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             last
);

    logic [CNT_W-1:0] cnt;

    // Parks at 1 so last stays high until the FSM reloads on its next state change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= len;
        end else if (cnt > CNT_W'(1)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/rtc_bus_if.sv
// Two-phase (address, gap, data) bus master for the external RTC chip.
// All pins are registered; output values are decoded from the next state.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for req_wr/req_rd; pins inactive
// A_SETUP   | address on bus, cs_n/ad_n low, strobe still high
// A_STROBE  | wr_n low latching the address into the RTC
// A_HOLD    | address held after strobe rises
// GAP       | cs_n high between phases, bus still driven
// D_SETUP   | cs_n low, ad_n high; write drives data, read floats the bus
// D_STROBE  | wr_n or rd_n low; read data captured on the final cycle
// D_HOLD    | data phase hold after strobe rises
// DONE      | one-cycle done pulse, then back to IDLE
module rtc_bus_if
    import rtc_bus_pkg::*;
#(
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_PULSE = T_PULSE_DEF,
    parameter int T_HOLD  = T_HOLD_DEF,
    parameter int T_GAP   = T_GAP_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_wr,
    input  logic       req_rd,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       cs_n,
    output logic       ad_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    localparam logic [CNT_W-1:0] LEN_SETUP = CNT_W'(T_SETUP);
    localparam logic [CNT_W-1:0] LEN_PULSE = CNT_W'(T_PULSE);
    localparam logic [CNT_W-1:0] LEN_HOLD  = CNT_W'(T_HOLD);
    localparam logic [CNT_W-1:0] LEN_GAP   = CNT_W'(T_GAP);

    rtc_state_e       state, state_nx;
    rtc_op_e          op_q, op_nx;
    logic [7:0]       addr_q, addr_nx;
    logic [7:0]       wdata_q, wdata_nx;
    logic             accept;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_len;
    logic             tmr_last;

    rtc_pins_t        pins_q, pins_nx;
    logic [7:0]       ad_out_nx;
    logic             busy_nx;
    logic             done_nx;

    rtc_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .len   (tmr_len),
        .last  (tmr_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            op_q    <= OP_WR;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state   <= state_nx;
            op_q    <= op_nx;
            addr_q  <= addr_nx;
            wdata_q <= wdata_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_wr || req_rd) begin
                    accept   = 1'b1;
                    state_nx = ST_A_SETUP;
                end
            end
            ST_A_SETUP:  if (tmr_last) state_nx = ST_A_STROBE;
            ST_A_STROBE: if (tmr_last) state_nx = ST_A_HOLD;
            ST_A_HOLD:   if (tmr_last) state_nx = ST_GAP;
            ST_GAP:      if (tmr_last) state_nx = ST_D_SETUP;
            ST_D_SETUP:  if (tmr_last) state_nx = ST_D_STROBE;
            ST_D_STROBE: if (tmr_last) state_nx = ST_D_HOLD;
            ST_D_HOLD:   if (tmr_last) state_nx = ST_DONE;
            ST_DONE:     state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase

        tmr_load = (state_nx != state);
        case (state_nx)
            ST_A_SETUP, ST_D_SETUP:   tmr_len = LEN_SETUP;
            ST_A_STROBE, ST_D_STROBE: tmr_len = LEN_PULSE;
            ST_A_HOLD, ST_D_HOLD:     tmr_len = LEN_HOLD;
            ST_GAP:                   tmr_len = LEN_GAP;
            default:                  tmr_len = '0;
        endcase

        // Write wins when both requests arrive together
        op_nx    = accept ? (req_wr ? OP_WR : OP_RD) : op_q;
        addr_nx  = accept ? addr  : addr_q;
        wdata_nx = accept ? wdata : wdata_q;
    end

    always_comb begin
        pins_nx   = PINS_IDLE;
        ad_out_nx = '0;
        busy_nx   = 1'b0;
        done_nx   = 1'b0;
        case (state_nx)
            ST_A_SETUP, ST_A_STROBE, ST_A_HOLD: begin
                pins_nx.cs_n  = 1'b0;
                pins_nx.ad_n  = 1'b0;
                pins_nx.ad_oe = 1'b1;
                pins_nx.wr_n  = (state_nx != ST_A_STROBE);
                ad_out_nx     = addr_nx;
                busy_nx       = 1'b1;
            end
            ST_GAP: begin
                pins_nx.ad_oe = 1'b1;
                ad_out_nx     = addr_nx;
                busy_nx       = 1'b1;
            end
            ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
                pins_nx.cs_n = 1'b0;
                busy_nx      = 1'b1;
                if (op_nx == OP_WR) begin
                    pins_nx.ad_oe = 1'b1;
                    pins_nx.wr_n  = (state_nx != ST_D_STROBE);
                    ad_out_nx     = wdata_nx;
                end else begin
                    pins_nx.rd_n  = (state_nx != ST_D_STROBE);
                end
            end
            ST_DONE: begin
                done_nx = 1'b1;
            end
            default: begin
                pins_nx = PINS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pins_q <= PINS_IDLE;
            ad_out <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            pins_q <= pins_nx;
            ad_out <= ad_out_nx;
            busy   <= busy_nx;
            done   <= done_nx;
        end
    end

    // Sampled on the final strobe cycle, while rd_n is still low at the RTC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (state == ST_D_STROBE && tmr_last && op_q == OP_RD) begin
            rdata <= ad_in;
        end
    end

    assign cs_n  = pins_q.cs_n;
    assign ad_n  = pins_q.ad_n;
    assign wr_n  = pins_q.wr_n;
    assign rd_n  = pins_q.rd_n;
    assign ad_oe = pins_q.ad_oe;

endmodule

// File: tb/tb_rtc_bus_if.sv
// Self-checking bench for rtc_bus_if: table vectors, random transactions and
// hand-written reset/overlap sequences against a cycle-indexed pin model.
module tb_rtc_bus_if;
    import rtc_bus_pkg::*;

    localparam int S    = T_SETUP_DEF;
    localparam int P    = T_PULSE_DEF;
    localparam int H    = T_HOLD_DEF;
    localparam int G    = T_GAP_DEF;
    localparam int SPAN = S + P + H;
    localparam int LAT  = 2 * SPAN + G + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_wr = 1'b0, req_rd = 1'b0;
    logic [7:0] addr = '0, wdata = '0, ad_in = '0;
    logic       busy, done, cs_n, ad_n, wr_n, rd_n, ad_oe;
    logic [7:0] rdata, ad_out;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] model_rdata = '0;

    always #5 clk = ~clk;

    rtc_bus_if dut (
        .clk    (clk),
        .reset  (reset),
        .req_wr (req_wr),
        .req_rd (req_rd),
        .addr   (addr),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .rdata  (rdata),
        .cs_n   (cs_n),
        .ad_n   (ad_n),
        .wr_n   (wr_n),
        .rd_n   (rd_n),
        .ad_out (ad_out),
        .ad_oe  (ad_oe),
        .ad_in  (ad_in)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Expected {busy,done,cs_n,ad_n,wr_n,rd_n,ad_oe} in cycle k after accept
    function automatic logic [6:0] exp_pins(int k, bit is_wr);
        logic b, dn, cs, ad, wr, rd, oe;
        int   j;
        b = 1'b1; dn = 1'b0; cs = 1'b1; ad = 1'b1; wr = 1'b1; rd = 1'b1; oe = 1'b0;
        if (k <= SPAN) begin
            cs = 1'b0; ad = 1'b0; oe = 1'b1;
            if (k > S && k <= S + P) wr = 1'b0;
        end else if (k <= SPAN + G) begin
            oe = 1'b1;
        end else if (k <= 2 * SPAN + G) begin
            j  = k - SPAN - G;
            cs = 1'b0;
            oe = is_wr;
            if (j > S && j <= S + P) begin
                if (is_wr) wr = 1'b0;
                else       rd = 1'b0;
            end
        end else begin
            b = 1'b0; dn = 1'b1;
        end
        return {b, dn, cs, ad, wr, rd, oe};
    endfunction

    // Starts at #1 after an edge with the DUT idle; ends one cycle after DONE
    task automatic run_txn(input string tag, input bit wr, input bit rd,
                           input logic [7:0] a, input logic [7:0] d, input logic [7:0] rv,
                           input int pulse_k, input bit hold);
        bit is_wr;
        int ds;
        is_wr  = wr;
        ds     = SPAN + G + S;
        req_wr = wr; req_rd = rd; addr = a; wdata = d;
        @(posedge clk); #1;
        if (!hold) begin
            req_wr = 1'b0; req_rd = 1'b0;
            addr = 8'($urandom); wdata = 8'($urandom);
        end
        for (int k = 1; k <= LAT; k++) begin
            ad_in = (k > ds && k <= ds + P) ? rv : ~rv;
            if (pulse_k > 0 && k == pulse_k) req_wr = 1'b1;
            if (pulse_k > 0 && k == pulse_k + 1) req_wr = 1'b0;
            check($sformatf("%s_pins_c%0d", tag, k),
                  {25'd0, busy, done, cs_n, ad_n, wr_n, rd_n, ad_oe}, {25'd0, exp_pins(k, is_wr)});
            if (k > S && k <= S + P)
                check($sformatf("%s_addr_c%0d", tag, k), {24'd0, ad_out}, {24'd0, a});
            if (is_wr && k > ds && k <= ds + P)
                check($sformatf("%s_wdata_c%0d", tag, k), {24'd0, ad_out}, {24'd0, d});
            if (k == LAT) begin
                if (!is_wr) model_rdata = rv;
                check($sformatf("%s_rdata", tag), {24'd0, rdata}, {24'd0, model_rdata});
            end
            @(posedge clk); #1;
        end
        check($sformatf("%s_idle_after", tag),
              {26'd0, busy, done, cs_n, wr_n, rd_n, ad_oe}, {26'd0, 6'b001110});
    endtask

    always @(negedge clk) begin
        if (!reset) check("strobe_excl", {31'd0, wr_n | rd_n}, 32'd1);
    end

    typedef struct {
        bit         wr;
        bit         rd;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] rv;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit   saw_done;
        int   r;
        bit   w, rr;

        vecs[0] = '{wr: 1, rd: 0, a: 8'h21, d: 8'h05,            rv: 8'h3C, exp_rdata: 8'h00};
        vecs[1] = '{wr: 0, rd: 1, a: 8'h23, d: 8'h00,            rv: 8'h59, exp_rdata: 8'h59};
        vecs[2] = '{wr: 1, rd: 1, a: 8'h30, d: 8'hAA,            rv: 8'h77, exp_rdata: 8'h59};
        vecs[3] = '{wr: 1, rd: 0, a: 8'h2F, d: CMD_XFER_TO_RTC,  rv: 8'h11, exp_rdata: 8'h59};
        vecs[4] = '{wr: 0, rd: 1, a: 8'hFF, d: CMD_XFER_FROM_RTC, rv: 8'hA5, exp_rdata: 8'hA5};
        vecs[5] = '{wr: 0, rd: 1, a: 8'h00, d: 8'h00,            rv: 8'h00, exp_rdata: 8'h00};

        @(posedge clk); #1;
        check("reset_pins", {25'd0, busy, done, cs_n, ad_n, wr_n, rd_n, ad_oe}, {25'd0, 7'b0011110});
        check("reset_data", {16'd0, rdata, ad_out}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].d,
                    vecs[i].rv, 0, 1'b0);
            check($sformatf("vec%0d_exp_rdata", i), {24'd0, rdata}, {24'd0, vecs[i].exp_rdata});
        end

        // Request during an active transaction is dropped
        run_txn("mid_req", 1'b1, 1'b0, 8'h40, 8'h12, 8'h00, 5, 1'b0);

        // Request held across DONE: accepted only after returning to IDLE
        run_txn("held_a", 1'b0, 1'b1, 8'h24, 8'h00, 8'h6B, 0, 1'b1);
        run_txn("held_b", 1'b0, 1'b1, 8'h24, 8'h00, 8'h6B, 0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            r  = $urandom_range(0, 2);
            w  = (r != 1);
            rr = (r != 0);
            run_txn($sformatf("rnd%0d", i), w, rr, 8'($urandom), 8'($urandom), 8'($urandom), 0, 1'b0);
        end

        // Reset during the address strobe aborts the transaction
        req_wr = 1'b1; addr = 8'h31; wdata = 8'h44;
        @(posedge clk); #1;
        req_wr = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_pre_wr_n", {31'd0, wr_n}, 32'd0);
        reset = 1'b1;
        #1;
        check("rst_abort", {27'd0, wr_n, cs_n, ad_oe, busy, done}, {27'd0, 5'b11000});
        model_rdata = '0;
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            if (done) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        check("rst_no_done", {31'd0, saw_done}, 32'd0);
        check("rst_idle", {29'd0, busy, cs_n, ad_oe}, {29'd0, 3'b010});

        run_txn("post_rst", 1'b0, 1'b1, 8'h23, 8'h00, 8'hC3, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
